// File: rtl/shift_sequencer.sv
// Command-driven sequencer for an 8-bit shift/rotate/Johnson count register.
// Accepts LOAD/ROL/ROR/JOHNSON over valid/ready and reports completion with a one-cycle done pulse.
module shift_sequencer #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             hold,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic [LEN_W-1:0] remaining,
  output logic             done,
  output logic             aborted
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_ROL  = 2'b01;
  localparam logic [1:0] OP_ROR  = 2'b10;
  localparam logic [1:0] OP_JOHN = 2'b11;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_count;
  logic [LEN_W-1:0] r_remaining;
  logic [1:0]       r_op;
  logic             r_aborted;
  logic [WIDTH-1:0] w_step;
  logic             w_accept;
  logic             w_is_load;
  logic             w_len_zero;
  logic             w_last_step;

  assign w_accept    = cmd_valid && (r_state == S_IDLE);
  assign w_is_load   = (cmd_op == OP_LOAD);
  assign w_len_zero  = (cmd_len == '0);
  assign w_last_step = (r_remaining == LEN_W'(1));

  // Next pattern for the operation latched at accept time.
  always_comb begin
    w_step = r_count;
    case (r_op)
      OP_ROL:  w_step = {r_count[WIDTH-2:0], r_count[WIDTH-1]};
      OP_ROR:  w_step = {r_count[0], r_count[WIDTH-1:1]};
      OP_JOHN: w_step = {r_count[WIDTH-2:0], ~r_count[WIDTH-1]};
      default: w_step = r_count;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_is_load || w_len_zero) w_state_nxt = S_DONE;
          else                         w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (abort)                    w_state_nxt = S_DONE;
        else if (!hold && w_last_step) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_count     <= WIDTH'(1);
      r_remaining <= '0;
      r_op        <= OP_LOAD;
      r_aborted   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      // aborted is only rewritten on entry to DONE so it qualifies that pulse.
      if (w_state_nxt == S_DONE && r_state != S_DONE) begin
        r_aborted <= (r_state == S_RUN) && abort;
      end
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op <= cmd_op;
            if (w_is_load)        r_count     <= cmd_data;
            else if (!w_len_zero) r_remaining <= cmd_len;
          end
        end
        S_RUN: begin
          if (!abort && !hold) begin
            r_count     <= w_step;
            r_remaining <= r_remaining - LEN_W'(1);
          end
        end
        S_DONE:  r_remaining <= '0;
        default: r_remaining <= '0;
      endcase
    end
  end

  assign cmd_ready = (r_state == S_IDLE);
  assign busy      = (r_state == S_RUN);
  assign done      = (r_state == S_DONE);
  assign count     = r_count;
  assign remaining = r_remaining;
  assign aborted   = r_aborted;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: vector table for the main flows,
// hand-written sequences for long Johnson runs, hold stalls and abort.
module tb_shift_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_len;
  logic [7:0] cmd_data;
  logic       hold;
  logic       abort;
  logic [7:0] count;
  logic       busy;
  logic [7:0] remaining;
  logic       done;
  logic       aborted;

  int checks   = 0;
  int failures = 0;

  shift_sequencer #(.WIDTH(8), .LEN_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_len   (cmd_len),
    .cmd_data  (cmd_data),
    .hold      (hold),
    .abort     (abort),
    .count     (count),
    .busy      (busy),
    .remaining (remaining),
    .done      (done),
    .aborted   (aborted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       vld;
    logic [1:0] op;
    logic [7:0] len;
    logic [7:0] data;
    logic       hld;
    logic       abt;
    logic [7:0] e_cnt;
    logic       e_rdy;
    logic       e_busy;
    logic       e_done;
    logic       e_ab;
    logic [7:0] e_rem;
  } vec_t;

  vec_t tbl[$];

  task automatic row(input logic rst, input logic vld, input logic [1:0] op,
                     input logic [7:0] len, input logic [7:0] data,
                     input logic hld, input logic abt,
                     input logic [7:0] e_cnt, input logic e_rdy, input logic e_busy,
                     input logic e_done, input logic e_ab, input logic [7:0] e_rem);
    vec_t v;
    v.rst = rst; v.vld = vld; v.op = op; v.len = len; v.data = data;
    v.hld = hld; v.abt = abt;
    v.e_cnt = e_cnt; v.e_rdy = e_rdy; v.e_busy = e_busy;
    v.e_done = e_done; v.e_ab = e_ab; v.e_rem = e_rem;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rst, input logic vld, input logic [1:0] op,
                       input logic [7:0] len, input logic [7:0] data,
                       input logic hld, input logic abt);
    reset = rst; cmd_valid = vld; cmd_op = op; cmd_len = len;
    cmd_data = data; hold = hld; abort = abt;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    drive(1'b1, 1'b0, 2'd0, 8'd0, 8'd0, 1'b0, 1'b0);

    //   rst vld op len    data   hld abt  count  rdy busy done ab rem
    row(1, 0, 0, 8'd0,  8'h00, 0, 0, 8'h01, 1, 0, 0, 0, 8'd0);
    row(0, 1, 0, 8'd0,  8'h81, 0, 0, 8'h81, 0, 0, 1, 0, 8'd0);
    row(0, 0, 0, 8'd0,  8'h00, 0, 0, 8'h81, 1, 0, 0, 0, 8'd0);
    row(0, 1, 1, 8'd8,  8'h00, 0, 0, 8'h81, 0, 1, 0, 0, 8'd8);
    row(0, 1, 0, 8'd0,  8'h55, 0, 0, 8'h03, 0, 1, 0, 0, 8'd7);
    row(0, 0, 0, 8'd0,  8'h00, 0, 0, 8'h06, 0, 1, 0, 0, 8'd6);
    row(0, 0, 0, 8'd0,  8'h00, 0, 0, 8'h0C, 0, 1, 0, 0, 8'd5);
    row(0, 0, 0, 8'd0,  8'h00, 0, 0, 8'h18, 0, 1, 0, 0, 8'd4);
    row(0, 0, 0, 8'd0,  8'h00, 0, 0, 8'h30, 0, 1, 0, 0, 8'd3);
    row(0, 0, 0, 8'd0,  8'h00, 0, 0, 8'h60, 0, 1, 0, 0, 8'd2);
    row(0, 0, 0, 8'd0,  8'h00, 0, 0, 8'hC0, 0, 1, 0, 0, 8'd1);
    row(0, 1, 0, 8'd0,  8'h55, 0, 0, 8'h81, 0, 0, 1, 0, 8'd0);
    row(0, 1, 0, 8'd0,  8'h55, 0, 0, 8'h81, 1, 0, 0, 0, 8'd0);
    row(1, 0, 0, 8'd0,  8'h00, 0, 0, 8'h01, 1, 0, 0, 0, 8'd0);
    row(0, 1, 2, 8'd1,  8'h00, 0, 0, 8'h01, 0, 1, 0, 0, 8'd1);
    row(0, 0, 0, 8'd0,  8'h00, 0, 0, 8'h80, 0, 0, 1, 0, 8'd0);
    row(0, 0, 0, 8'd0,  8'h00, 0, 0, 8'h80, 1, 0, 0, 0, 8'd0);
    row(0, 1, 1, 8'd0,  8'h00, 0, 0, 8'h80, 0, 0, 1, 0, 8'd0);
    row(0, 0, 0, 8'd0,  8'h00, 0, 0, 8'h80, 1, 0, 0, 0, 8'd0);
    row(0, 1, 2, 8'd5,  8'h00, 0, 0, 8'h80, 0, 1, 0, 0, 8'd5);
    row(0, 0, 0, 8'd0,  8'h00, 0, 0, 8'h40, 0, 1, 0, 0, 8'd4);
    row(1, 1, 0, 8'd0,  8'hAA, 0, 0, 8'h01, 1, 0, 0, 0, 8'd0);
    row(0, 1, 3, 8'd3,  8'h00, 0, 0, 8'h01, 0, 1, 0, 0, 8'd3);
    row(0, 0, 0, 8'd0,  8'h00, 0, 0, 8'h03, 0, 1, 0, 0, 8'd2);
    row(0, 0, 0, 8'd0,  8'h00, 0, 0, 8'h07, 0, 1, 0, 0, 8'd1);
    row(0, 0, 0, 8'd0,  8'h00, 0, 0, 8'h0F, 0, 0, 1, 0, 8'd0);
    row(0, 0, 0, 8'd0,  8'h00, 0, 0, 8'h0F, 1, 0, 0, 0, 8'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].vld, tbl[i].op, tbl[i].len, tbl[i].data,
            tbl[i].hld, tbl[i].abt);
      tick();
      chk($sformatf("row%0d count", i),     32'(count),     32'(tbl[i].e_cnt));
      chk($sformatf("row%0d cmd_ready", i), 32'(cmd_ready), 32'(tbl[i].e_rdy));
      chk($sformatf("row%0d busy", i),      32'(busy),      32'(tbl[i].e_busy));
      chk($sformatf("row%0d done", i),      32'(done),      32'(tbl[i].e_done));
      chk($sformatf("row%0d aborted", i),   32'(aborted),   32'(tbl[i].e_ab));
      chk($sformatf("row%0d remaining", i), 32'(remaining), 32'(tbl[i].e_rem));
    end

    // JOHNSON len=16 from 0000_1111 wraps back to the same pattern.
    drive(1'b0, 1'b1, 2'd3, 8'd16, 8'h00, 1'b0, 1'b0);
    tick();
    chk("j16 accept rem", 32'(remaining), 32'd16);
    drive(1'b0, 1'b0, 2'd0, 8'd0, 8'h00, 1'b0, 1'b0);
    for (int i = 1; i < 16; i++) begin
      tick();
      chk($sformatf("j16 step%0d rem", i), 32'(remaining), 32'(16 - i));
      chk($sformatf("j16 step%0d busy", i), 32'(busy), 32'd1);
    end
    tick();
    chk("j16 final count", 32'(count), 32'h0F);
    chk("j16 done", 32'(done), 32'd1);
    tick();
    chk("j16 idle ready", 32'(cmd_ready), 32'd1);

    // ROR len=5 from reset, held for two cycles after the second step.
    drive(1'b1, 1'b0, 2'd0, 8'd0, 8'h00, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b1, 2'd2, 8'd5, 8'h00, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 2'd0, 8'd0, 8'h00, 1'b0, 1'b0);
    tick();
    chk("hold step1 count", 32'(count), 32'h80);
    tick();
    chk("hold step2 count", 32'(count), 32'h40);
    hold = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk($sformatf("hold%0d count", i), 32'(count), 32'h40);
      chk($sformatf("hold%0d rem", i), 32'(remaining), 32'd3);
      chk($sformatf("hold%0d done", i), 32'(done), 32'd0);
    end
    hold = 1'b0;
    tick();
    chk("hold step3 count", 32'(count), 32'h20);
    tick();
    chk("hold step4 count", 32'(count), 32'h10);
    chk("hold step4 done", 32'(done), 32'd0);
    tick();
    chk("hold final count", 32'(count), 32'h08);
    chk("hold final done", 32'(done), 32'd1);
    chk("hold final aborted", 32'(aborted), 32'd0);
    tick();

    // JOHNSON len=10 from 0000_0000, aborted after the 4th step,
    // with a competing LOAD held on cmd_valid throughout RUN and DONE.
    drive(1'b0, 1'b1, 2'd0, 8'd0, 8'h00, 1'b0, 1'b0);
    tick();
    chk("abort preload", 32'(count), 32'h00);
    drive(1'b0, 1'b0, 2'd0, 8'd0, 8'h00, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b1, 2'd3, 8'd10, 8'h00, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b1, 2'd0, 8'd0, 8'hFF, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("abort run%0d ready", i), 32'(cmd_ready), 32'd0);
    end
    chk("abort pre count", 32'(count), 32'h0F);
    abort = 1'b1;
    hold  = 1'b1;
    tick();
    chk("abort count", 32'(count), 32'h0F);
    chk("abort rem", 32'(remaining), 32'd6);
    chk("abort done", 32'(done), 32'd1);
    chk("abort aborted", 32'(aborted), 32'd1);
    chk("abort ready", 32'(cmd_ready), 32'd0);
    abort = 1'b0;
    hold  = 1'b0;
    tick();
    chk("post abort count", 32'(count), 32'h0F);
    chk("post abort ready", 32'(cmd_ready), 32'd1);
    chk("post abort done", 32'(done), 32'd0);
    chk("post abort rem", 32'(remaining), 32'd0);
    drive(1'b0, 1'b0, 2'd0, 8'd0, 8'h00, 1'b0, 1'b1);
    tick();
    chk("idle abort done", 32'(done), 32'd0);
    chk("idle abort ready", 32'(cmd_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Command-driven controller for the 8-bit shift counter datapath. It owns the counter register and sequences it through load, rotate-left, rotate-right and Johnson (twisted-ring) stepping for a programmed number of cycles.
- Commands arrive over a valid/ready handshake. Completion is reported by a one-cycle done pulse.
- Sits between a host/test controller and any logic consuming the count pattern.

Parameters:
- WIDTH, 8, width of the count register (must be >= 2)
- LEN_W, 8, width of the step-length field and of the remaining-steps counter

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  controller can accept a command
- cmd_op  input  2  00=LOAD, 01=ROL, 10=ROR, 11=JOHNSON
- cmd_len  input  LEN_W  number of steps (ignored for LOAD)
- cmd_data  input  WIDTH  pattern for LOAD (ignored otherwise)
- hold  input  1  freeze stepping while high (RUN only)
- abort  input  1  terminate the running command early
- count  output  WIDTH  current counter pattern
- busy  output  1  high while in RUN
- remaining  output  LEN_W  steps still to perform
- done  output  1  one-cycle completion pulse
- aborted  output  1  qualifies done: the command was aborted

Behaviour:
- Clock is clk; reset is synchronous and active-high. Reset has priority over every other input, including mid-command.
- Reset values:
  - count = {{WIDTH-1{0}},1} (0000_0001)
  - state = IDLE; cmd_ready = 1
  - busy = 0, done = 0, aborted = 0, remaining = 0
- States: IDLE, RUN, DONE. Outputs by state:
  - cmd_ready = (state==IDLE)
  - busy = (state==RUN)
  - done = (state==DONE)
  - aborted: registered; set on entry to DONE via abort, cleared on entry to DONE otherwise. Valid only while done=1; reads 0 after reset.
- Accept: a command is accepted on an edge where cmd_valid && cmd_ready. The command is captured at that edge (call it edge k). cmd_valid while not ready is ignored, not queued.
- LOAD: count <= cmd_data at edge k; state -> DONE.
- ROL/ROR/JOHNSON, cmd_len = 0: state -> DONE at edge k; count unchanged.
- ROL/ROR/JOHNSON, cmd_len = N > 0: state -> RUN and remaining <= N at edge k.
- RUN, hold=0, abort=0: one step per edge and remaining decrements by 1. On the edge where remaining goes 1 -> 0, state -> DONE.
  - Result: steps at edges k+1..k+N, done high in the cycle after edge k+N, state back to IDLE at edge k+N+1.
- RUN, hold=1: count and remaining frozen; latency extends by one cycle per held cycle.
- RUN, abort=1: no step at that edge; state -> DONE with aborted=1; remaining keeps its value. abort beats hold. abort is ignored in IDLE and DONE.
- DONE lasts exactly one cycle, then IDLE. remaining <= 0 on leaving DONE. No command is accepted while in DONE.
- Step functions (W=WIDTH):
  - ROL: {count[W-2:0], count[W-1]}
  - ROR: {count[0], count[W-1:1]}
  - JOHNSON: {count[W-2:0], ~count[W-1]}
- Wrap-around: ROL/ROR by a multiple of W returns the original pattern. JOHNSON has period 2W.
- cmd_op, cmd_len and cmd_data are sampled only at the accept edge. Changes during RUN have no effect.

Test Plan:
- Reset then idle: after reset, count=0000_0001, cmd_ready=1, busy=0, done=0. Reset asserted mid-RUN restores the same values at the next edge.
- LOAD 1000_0001, then ROL len=8: count returns to 1000_0001. done pulses exactly once, 9 cycles after the ROL accept edge. busy is high for 8 cycles.
- From reset, JOHNSON len=3: count goes 0000_0011, 0000_0111, 0000_1111 on successive edges; remaining goes 3, 2, 1, 0. Then JOHNSON len=16: count returns to 0000_1111.
- From reset, ROR len=1: count=1000_0000, done one cycle later, aborted=0. Also ROL len=0: done the cycle after accept, count unchanged.
- ROR len=5 with hold high for 2 cycles after the second step: count stalls for 2 cycles, done arrives 2 cycles late, and the final count equals the unheld result.
- JOHNSON len=10 with abort on the cycle after the 4th step: count=0000_1111 is frozen, remaining=6, done=1 with aborted=1. cmd_valid asserted during RUN and DONE is not accepted (cmd_ready=0).
